// File: rtl/ptpv2_pkg.sv
// Shared PTPv2 TX definitions: messageType codes, tsu_cfg bit positions,
// scheduler state encoding and the per-frame context record.
package ptpv2_pkg;

    localparam logic [3:0] MT_SYNC        = 4'h0;
    localparam logic [3:0] MT_DELAY_REQ   = 4'h1;
    localparam logic [3:0] MT_PDELAY_REQ  = 4'h2;
    localparam logic [3:0] MT_PDELAY_RESP = 4'h3;

    localparam int CFG_ONE_STEP = 0;
    localparam int CTX_W        = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0]  msg_type;
        logic        is_ptp;
        logic [10:0] addr_base;
    } ctx_t;

    // Message types whose timestamp field is rewritten in flight.
    function automatic logic emb_type(input logic [3:0] t);
        return (t == MT_SYNC) || (t == MT_PDELAY_RESP);
    endfunction

    // Two-step path needs every event message; one-step still needs an
    // egress capture for the request types it cannot embed.
    function automatic logic ts_req_needed(input logic one_step, input ctx_t c);
        return (!one_step && c.is_ptp && (c.msg_type < 4'h4)) ||
               (one_step && ((c.msg_type == MT_DELAY_REQ) || (c.msg_type == MT_PDELAY_REQ)));
    endfunction

endpackage

// File: rtl/tx_ctx_fifo.sv
// Context FIFO: registered storage, head visible combinationally from storage.
// Latency: a push becomes poppable one cycle later. Push while full is dropped (caller holds).
// Backpressure: full_o reflects the registered level only, pops do not free a slot early.
module tx_ctx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;

    assign full_o    = (level_q == FULL_LVL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/tx_ptp_ctx_sched.sv
// TX PTP per-frame context scheduler; optional ACTIVE watchdog under TX_CTX_TIMEOUT_EN.
// Latency: context, emb_en and ts_req appear 1 enabled cycle after the sfd pulse.
// Backpressure: ctx_ready_o low while the context FIFO is full; parser holds ctx_valid_i.
module tx_ptp_ctx_sched
    import ptpv2_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 2047
) (
    input  logic          tx_clk,
    input  logic          tx_rst_n,
    input  logic          tx_clk_en_i,
    input  logic [31:0]   tsu_cfg_i,
    input  logic          ctx_valid_i,
    output logic          ctx_ready_o,
    input  logic [3:0]    ctx_msg_type_i,
    input  logic          ctx_is_ptp_i,
    input  logic [10:0]   ctx_addr_base_i,
    input  logic          sfd_i,
    input  logic          eof_i,
    input  logic          err_clr_i,
    output logic          cur_valid_o,
    output logic [3:0]    cur_msg_type_o,
    output logic          cur_is_ptp_o,
    output logic [10:0]   cur_addr_base_o,
    output logic          emb_en_o,
    output logic          ts_req_o,
    output logic          busy_o,
    output logic [AW:0]   level_o,
    output logic          udf_err_o,
    output logic          abort_err_o,
    output logic          tmo_err_o
);

    state_e           state_q, state_d;
    ctx_t             cur_q, cur_d;
    logic             cur_vld_q, cur_vld_d;
    logic             emb_en_q, emb_en_d;
    logic             ts_req_q, ts_req_d;
    logic             udf_err_q, udf_err_d;
    logic             abort_err_q, abort_err_d;

    logic             sfd, eof, err_clr, one_step, active;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CTX_W-1:0] head_dat;
    ctx_t             head, ctx_in;
    logic [30:0]      cfg_unused;

    assign sfd        = tx_clk_en_i && sfd_i;
    assign eof        = tx_clk_en_i && eof_i;
    assign err_clr    = tx_clk_en_i && err_clr_i;
    assign one_step   = tsu_cfg_i[CFG_ONE_STEP];
    assign cfg_unused = tsu_cfg_i[31:1];
    assign active     = (state_q == ST_ACTIVE);

    assign ctx_in    = '{msg_type: ctx_msg_type_i, is_ptp: ctx_is_ptp_i, addr_base: ctx_addr_base_i};
    assign head      = ctx_t'(head_dat);
    assign fifo_push = tx_clk_en_i && ctx_valid_i && !fifo_full;

    tx_ctx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (CTX_W)
    ) u_fifo (
        .clk_i      (tx_clk),
        .rst_n_i    (tx_rst_n),
        .push_i     (fifo_push),
        .push_dat_i (ctx_in),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level_o)
    );

`ifdef TX_CTX_TIMEOUT_EN
    localparam int             TCW      = $clog2(TIMEOUT + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           tmo_err_q, tmo_err_d;
    logic           tmo_hit;

    // Frame events in the expiring cycle take precedence over the watchdog.
    assign tmo_hit   = tx_clk_en_i && active && !sfd && !eof && (tmo_cnt_q == TMO_LAST);
    assign tmo_err_o = tmo_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign tmo_err_o      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cur_vld_d   = cur_vld_q;
        emb_en_d    = emb_en_q;
        ts_req_d    = tx_clk_en_i ? 1'b0 : ts_req_q;
        udf_err_d   = udf_err_q;
        abort_err_d = abort_err_q;
        fifo_pop    = 1'b0;
`ifdef TX_CTX_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        if (tx_clk_en_i && active) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (err_clr) begin
            tmo_err_d = 1'b0;
        end
        if (tmo_hit) begin
            state_d   = ST_IDLE;
            cur_vld_d = 1'b0;
            emb_en_d  = 1'b0;
            tmo_err_d = 1'b1;
        end
        if (sfd) begin
            tmo_cnt_d = '0;
        end
`endif
        if (err_clr) begin
            udf_err_d   = 1'b0;
            abort_err_d = 1'b0;
        end
        if (active && eof) begin
            state_d   = ST_IDLE;
            cur_vld_d = 1'b0;
            emb_en_d  = 1'b0;
        end
        if (active && sfd && !eof) begin
            abort_err_d = 1'b1;
        end
        if (sfd) begin
            state_d = ST_ACTIVE;
            if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                cur_d     = head;
                cur_vld_d = 1'b1;
                emb_en_d  = one_step && head.is_ptp && emb_type(head.msg_type);
                ts_req_d  = ts_req_needed(one_step, head);
            end else begin
                cur_d     = '0;
                cur_vld_d = 1'b0;
                emb_en_d  = 1'b0;
                udf_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            cur_vld_q   <= 1'b0;
            emb_en_q    <= 1'b0;
            ts_req_q    <= 1'b0;
            udf_err_q   <= 1'b0;
            abort_err_q <= 1'b0;
`ifdef TX_CTX_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cur_vld_q   <= cur_vld_d;
            emb_en_q    <= emb_en_d;
            ts_req_q    <= ts_req_d;
            udf_err_q   <= udf_err_d;
            abort_err_q <= abort_err_d;
`ifdef TX_CTX_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
`endif
        end
    end

    assign ctx_ready_o     = !fifo_full;
    assign cur_valid_o     = cur_vld_q;
    assign cur_msg_type_o  = cur_q.msg_type;
    assign cur_is_ptp_o    = cur_q.is_ptp;
    assign cur_addr_base_o = cur_q.addr_base;
    assign emb_en_o        = emb_en_q;
    assign ts_req_o        = ts_req_q;
    assign busy_o          = active;
    assign udf_err_o       = udf_err_q;
    assign abort_err_o     = abort_err_q;

endmodule

// File: tb/tb_tx_ptp_ctx_sched.sv
// Bench for tx_ptp_ctx_sched: vector table of contexts plus hand sequences
// for full FIFO, errors, clock enable, reset and (optionally) timeout.
module tb_tx_ptp_ctx_sched;
    import ptpv2_pkg::*;

    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int TIMEOUT = 16;

    logic          tx_clk = 1'b0;
    logic          tx_rst_n = 1'b0;
    logic          tx_clk_en_i = 1'b1;
    logic [31:0]   tsu_cfg_i = '0;
    logic          ctx_valid_i = 1'b0;
    logic          ctx_ready_o;
    logic [3:0]    ctx_msg_type_i = '0;
    logic          ctx_is_ptp_i = 1'b0;
    logic [10:0]   ctx_addr_base_i = '0;
    logic          sfd_i = 1'b0;
    logic          eof_i = 1'b0;
    logic          err_clr_i = 1'b0;
    logic          cur_valid_o;
    logic [3:0]    cur_msg_type_o;
    logic          cur_is_ptp_o;
    logic [10:0]   cur_addr_base_o;
    logic          emb_en_o;
    logic          ts_req_o;
    logic          busy_o;
    logic [AW:0]   level_o;
    logic          udf_err_o;
    logic          abort_err_o;
    logic          tmo_err_o;

    tx_ptp_ctx_sched #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .tx_clk          (tx_clk),
        .tx_rst_n        (tx_rst_n),
        .tx_clk_en_i     (tx_clk_en_i),
        .tsu_cfg_i       (tsu_cfg_i),
        .ctx_valid_i     (ctx_valid_i),
        .ctx_ready_o     (ctx_ready_o),
        .ctx_msg_type_i  (ctx_msg_type_i),
        .ctx_is_ptp_i    (ctx_is_ptp_i),
        .ctx_addr_base_i (ctx_addr_base_i),
        .sfd_i           (sfd_i),
        .eof_i           (eof_i),
        .err_clr_i       (err_clr_i),
        .cur_valid_o     (cur_valid_o),
        .cur_msg_type_o  (cur_msg_type_o),
        .cur_is_ptp_o    (cur_is_ptp_o),
        .cur_addr_base_o (cur_addr_base_o),
        .emb_en_o        (emb_en_o),
        .ts_req_o        (ts_req_o),
        .busy_o          (busy_o),
        .level_o         (level_o),
        .udf_err_o       (udf_err_o),
        .abort_err_o     (abort_err_o),
        .tmo_err_o       (tmo_err_o)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic one_step;
        ctx_t c;
        logic emb;
        logic ts;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    ctx_t sb_q[$];
    vec_t vt[10];

    function automatic ctx_t mk_ctx(input logic [3:0] t, input logic p, input logic [10:0] b);
        ctx_t c;
        c.msg_type  = t;
        c.is_ptp    = p;
        c.addr_base = b;
        return c;
    endfunction

    function automatic vec_t mk_vec(input logic os, input logic [3:0] t, input logic p,
                                    input logic [10:0] b, input logic emb, input logic ts);
        vec_t v;
        v.one_step = os;
        v.c        = mk_ctx(t, p, b);
        v.emb      = emb;
        v.ts       = ts;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic drive_ctx(input ctx_t c);
        ctx_valid_i = 1'b1;
        {ctx_msg_type_i, ctx_is_ptp_i, ctx_addr_base_i} = c;
    endtask

    task automatic push_ctx(input ctx_t c);
        drive_ctx(c);
        tick();
        ctx_valid_i = 1'b0;
        sb_q.push_back(c);
    endtask

    task automatic chk_load(input string tag, input logic emb, input logic ts);
        ctx_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty at load", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_valid"}, 32'(cur_valid_o), 32'd1);
        chk({tag, "_type"},  32'(cur_msg_type_o), 32'(e.msg_type));
        chk({tag, "_ptp"},   32'(cur_is_ptp_o), 32'(e.is_ptp));
        chk({tag, "_base"},  32'(cur_addr_base_o), 32'(e.addr_base));
        chk({tag, "_emb"},   32'(emb_en_o), 32'(emb));
        chk({tag, "_ts"},    32'(ts_req_o), 32'(ts));
        chk({tag, "_busy"},  32'(busy_o), 32'd1);
    endtask

    task automatic frame_edge(input logic s, input logic e);
        sfd_i = s;
        eof_i = e;
        tick();
        sfd_i = 1'b0;
        eof_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk_vec(1'b1, 4'h0, 1'b1, 11'd42,   1'b1, 1'b0);
        vt[1] = mk_vec(1'b0, 4'h1, 1'b1, 11'd100,  1'b0, 1'b1);
        vt[2] = mk_vec(1'b0, 4'h8, 1'b1, 11'd7,    1'b0, 1'b0);
        vt[3] = mk_vec(1'b1, 4'h3, 1'b1, 11'd2047, 1'b1, 1'b0);
        vt[4] = mk_vec(1'b1, 4'h1, 1'b1, 11'd5,    1'b0, 1'b1);
        vt[5] = mk_vec(1'b1, 4'h0, 1'b0, 11'd9,    1'b0, 1'b0);
        vt[6] = mk_vec(1'b0, 4'h0, 1'b0, 11'd1,    1'b0, 1'b0);
        vt[7] = mk_vec(1'b0, 4'h3, 1'b1, 11'd300,  1'b0, 1'b1);
        vt[8] = mk_vec(1'b1, 4'h2, 1'b1, 11'd33,   1'b0, 1'b1);
        vt[9] = mk_vec(1'b0, 4'h4, 1'b1, 11'd600,  1'b0, 1'b0);

        #12;
        chk("rst_ready", 32'(ctx_ready_o), 32'd1);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_cur_valid", 32'(cur_valid_o), 32'd0);
        chk("rst_base", 32'(cur_addr_base_o), 32'd0);
        chk("rst_emb", 32'(emb_en_o), 32'd0);
        chk("rst_ts", 32'(ts_req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_errs", 32'({udf_err_o, abort_err_o, tmo_err_o}), 32'd0);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            tsu_cfg_i = {31'd0, vt[i].one_step};
            push_ctx(vt[i].c);
            frame_edge(1'b1, 1'b0);
            chk_load($sformatf("vec%0d", i), vt[i].emb, vt[i].ts);
            tick();
            chk($sformatf("vec%0d_ts_pulse", i), 32'(ts_req_o), 32'd0);
            frame_edge(1'b0, 1'b1);
            chk($sformatf("vec%0d_eof_valid", i), 32'(cur_valid_o), 32'd0);
            chk($sformatf("vec%0d_eof_emb", i), 32'(emb_en_o), 32'd0);
            chk($sformatf("vec%0d_eof_busy", i), 32'(busy_o), 32'd0);
            chk($sformatf("vec%0d_eof_base_hold", i), 32'(cur_addr_base_o), 32'(vt[i].c.addr_base));
        end

        // eof in IDLE is ignored
        frame_edge(1'b0, 1'b1);
        chk("idle_eof_busy", 32'(busy_o), 32'd0);
        chk("idle_eof_errs", 32'({udf_err_o, abort_err_o}), 32'd0);

        // Fill to DEPTH, then pop while the 5th push is pending
        tsu_cfg_i = '0;
        for (int k = 0; k < 4; k++) push_ctx(mk_ctx(4'h8, 1'b0, 11'(100 + k)));
        chk("full_level", 32'(level_o), 32'd4);
        chk("full_ready", 32'(ctx_ready_o), 32'd0);
        drive_ctx(mk_ctx(4'h8, 1'b0, 11'd200));
        tick();
        chk("full_held_level", 32'(level_o), 32'd4);
        frame_edge(1'b1, 1'b0);
        chk_load("full_pop", 1'b0, 1'b0);
        chk("full_pop_refused", 32'(level_o), 32'd3);
        tick();
        ctx_valid_i = 1'b0;
        sb_q.push_back(mk_ctx(4'h8, 1'b0, 11'd200));
        chk("full_push_next", 32'(level_o), 32'd4);
        for (int k = 0; k < 4; k++) begin
            frame_edge(1'b1, 1'b1);
            chk_load($sformatf("order%0d", k), 1'b0, 1'b0);
        end
        chk("eofsfd_no_abort", 32'(abort_err_o), 32'd0);
        frame_edge(1'b0, 1'b1);
        chk("drain_level", 32'(level_o), 32'd0);

        // Underflow, abort, clear
        frame_edge(1'b1, 1'b0);
        chk("udf_set", 32'(udf_err_o), 32'd1);
        chk("udf_cur_valid", 32'(cur_valid_o), 32'd0);
        chk("udf_busy", 32'(busy_o), 32'd1);
        chk("udf_base_zero", 32'(cur_addr_base_o), 32'd0);
        chk("udf_no_abort", 32'(abort_err_o), 32'd0);
        tsu_cfg_i = 32'd1;
        push_ctx(mk_ctx(4'h0, 1'b1, 11'd77));
        frame_edge(1'b1, 1'b0);
        chk("abort_set", 32'(abort_err_o), 32'd1);
        chk_load("abort_load", 1'b1, 1'b0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr_errs", 32'({udf_err_o, abort_err_o, tmo_err_o}), 32'd0);
        push_ctx(mk_ctx(4'h3, 1'b1, 11'd500));
        frame_edge(1'b1, 1'b1);
        chk_load("eofsfd_load", 1'b1, 1'b0);
        chk("eofsfd_errs", 32'({udf_err_o, abort_err_o}), 32'd0);
        frame_edge(1'b0, 1'b1);
        sfd_i = 1'b1;
        err_clr_i = 1'b1;
        tick();
        sfd_i = 1'b0;
        err_clr_i = 1'b0;
        chk("set_beats_clr", 32'(udf_err_o), 32'd1);
        frame_edge(1'b0, 1'b1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr_again", 32'(udf_err_o), 32'd0);

        // Clock enable 1-of-10
        tsu_cfg_i = '0;
        drive_ctx(mk_ctx(4'h1, 1'b1, 11'd321));
        tx_clk_en_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("en_push_blocked", 32'(level_o), 32'd0);
        tx_clk_en_i = 1'b1;
        tick();
        tx_clk_en_i = 1'b0;
        ctx_valid_i = 1'b0;
        sb_q.push_back(mk_ctx(4'h1, 1'b1, 11'd321));
        chk("en_push_taken", 32'(level_o), 32'd1);
        sfd_i = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("en_sfd_blocked", 32'(busy_o), 32'd0);
        tx_clk_en_i = 1'b1;
        tick();
        tx_clk_en_i = 1'b0;
        sfd_i = 1'b0;
        chk_load("en_load", 1'b0, 1'b1);
        eof_i = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("en_eof_blocked", 32'(cur_valid_o), 32'd1);
        chk("en_ts_hold", 32'(ts_req_o), 32'd1);
        tx_clk_en_i = 1'b1;
        tick();
        eof_i = 1'b0;
        chk("en_eof_busy", 32'(busy_o), 32'd0);
        chk("en_eof_ts", 32'(ts_req_o), 32'd0);

        // Async reset mid-frame flushes the FIFO
        tsu_cfg_i = 32'd1;
        push_ctx(mk_ctx(4'h0, 1'b1, 11'd11));
        push_ctx(mk_ctx(4'h3, 1'b1, 11'd12));
        frame_edge(1'b1, 1'b0);
        chk_load("pre_rst", 1'b1, 1'b0);
        #2;
        tx_rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("arst_level", 32'(level_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_outs", 32'({cur_valid_o, emb_en_o, ts_req_o, cur_is_ptp_o}), 32'd0);
        chk("arst_base", 32'(cur_addr_base_o), 32'd0);
        chk("arst_ready", 32'(ctx_ready_o), 32'd1);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        tick();
        frame_edge(1'b1, 1'b0);
        chk("arst_flushed_udf", 32'(udf_err_o), 32'd1);
        chk("arst_flushed_valid", 32'(cur_valid_o), 32'd0);
        frame_edge(1'b0, 1'b1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;

`ifdef TX_CTX_TIMEOUT_EN
        tsu_cfg_i = '0;
        push_ctx(mk_ctx(4'h8, 1'b0, 11'd1));
        frame_edge(1'b1, 1'b0);
        chk_load("tmo_load", 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_not_yet_busy", 32'(busy_o), 32'd1);
        chk("tmo_not_yet_err", 32'(tmo_err_o), 32'd0);
        tick();
        chk("tmo_busy", 32'(busy_o), 32'd0);
        chk("tmo_err", 32'(tmo_err_o), 32'd1);
        chk("tmo_valid", 32'(cur_valid_o), 32'd0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        push_ctx(mk_ctx(4'h8, 1'b0, 11'd2));
        frame_edge(1'b1, 1'b0);
        chk_load("tmo2_load", 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        frame_edge(1'b0, 1'b1);
        chk("tmo_eof15_busy", 32'(busy_o), 32'd0);
        chk("tmo_eof15_err", 32'(tmo_err_o), 32'd0);
`else
        tsu_cfg_i = '0;
        push_ctx(mk_ctx(4'h8, 1'b0, 11'd1));
        frame_edge(1'b1, 1'b0);
        chk_load("long_load", 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        chk("no_tmo_busy", 32'(busy_o), 32'd1);
        chk("no_tmo_err", 32'(tmo_err_o), 32'd0);
        frame_edge(1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
